// File: rtl/minpool_9bit.sv
// minpool_9bit: streaming min-pooling stage for 9-bit sign-magnitude samples.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data/in_last
//   upstream handshake; out_valid/out_ready/out_data/out_count result port.
module minpool_9bit #(
  parameter int WINDOW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_data,
  output logic [4:0] out_count
);

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_t;

  state_t     r_state;
  state_t     w_nxt_state;
  logic [8:0] r_acc;
  logic [8:0] w_nxt_acc;
  logic [4:0] r_cnt;
  logic [4:0] w_nxt_cnt;
  logic [8:0] r_out_data;
  logic [8:0] w_nxt_out_data;
  logic [4:0] r_out_count;
  logic [4:0] w_nxt_out_count;
  logic       r_out_valid;
  logic       w_nxt_out_valid;

  logic       w_xfer_in;
  logic       w_xfer_out;
  logic [8:0] w_min;
  logic [8:0] w_m;
  logic [4:0] w_n;
  logic       w_close;

  // Sign-magnitude ordering: any negative (incl. -0) beats any positive;
  // among negatives the larger magnitude is smaller.
  function automatic logic [8:0] sm_min(
    input logic [8:0] a,
    input logic [8:0] b
  );
    logic [8:0] r;
    if (a[8] != b[8])
      r = a[8] ? a : b;
    else if (a[8])
      r = (a[7:0] >= b[7:0]) ? a : b;
    else
      r = (a[7:0] <= b[7:0]) ? a : b;
    return r;
  endfunction

  assign in_ready   = !r_out_valid || out_ready;
  assign w_xfer_in  = in_valid && in_ready;
  assign w_xfer_out = r_out_valid && out_ready;
  assign w_min      = sm_min(r_acc, in_data);
  assign w_m        = (r_state == S_IDLE) ? in_data : w_min;
  assign w_n        = r_cnt + 5'd1;
  assign w_close    = in_last || (w_n == 5'(WINDOW));

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_acc       = r_acc;
    w_nxt_cnt       = r_cnt;
    w_nxt_out_data  = r_out_data;
    w_nxt_out_count = r_out_count;
    w_nxt_out_valid = r_out_valid;
    if (w_xfer_out)
      w_nxt_out_valid = 1'b0;
    // A completing window overrides the consume above: no bubble.
    if (w_xfer_in) begin
      if (w_close) begin
        w_nxt_out_data  = w_m;
        w_nxt_out_count = w_n;
        w_nxt_out_valid = 1'b1;
        w_nxt_cnt       = 5'd0;
        w_nxt_state     = S_IDLE;
      end else begin
        w_nxt_acc   = w_m;
        w_nxt_cnt   = w_n;
        w_nxt_state = S_ACCUM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= 9'h000;
      r_cnt       <= 5'd0;
      r_out_data  <= 9'h000;
      r_out_count <= 5'd0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_acc       <= w_nxt_acc;
      r_cnt       <= w_nxt_cnt;
      r_out_data  <= w_nxt_out_data;
      r_out_count <= w_nxt_out_count;
      r_out_valid <= w_nxt_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_minpool_9bit.sv
// tb_minpool_9bit: directed self-checking bench for minpool_9bit.
// Hand-computed expected results, immediate assertions per check.
module tb_minpool_9bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;
  logic [4:0] out_count;

  int checks;
  int errors;

  minpool_9bit #(.WINDOW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [8:0] obs,
                     input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [8:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_out(input string tag,
                         input logic v,
                         input logic [8:0] d,
                         input logic [4:0] c);
    chk({tag, "_valid"}, {8'h0, out_valid}, {8'h0, v});
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_count"}, {4'h0, out_count}, {4'h0, c});
  endtask

  logic [8:0] stream [12];
  logic [8:0] smin [3];

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 9'h1AA;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset held 3 cycles with in_valid asserted
    repeat (3) tick();
    chk_out("reset", 1'b0, 9'h000, 5'd0);
    chk("reset_in_ready", {8'h0, in_ready}, 9'h001);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Mixed signs: a counted reset sample would close early
    send(9'h003, 1'b0);
    send(9'h105, 1'b0);
    send(9'h007, 1'b0);
    chk("mixed_not_yet", {8'h0, out_valid}, 9'h000);
    send(9'h102, 1'b0);
    chk_out("mixed", 1'b1, 9'h105, 5'd4);

    // All positive
    send(9'h010, 1'b0);
    chk("consume_clears", {8'h0, out_valid}, 9'h000);
    send(9'h004, 1'b0);
    send(9'h0FF, 1'b0);
    send(9'h004, 1'b0);
    chk_out("allpos", 1'b1, 9'h004, 5'd4);

    // All negative
    send(9'h181, 1'b0);
    send(9'h1FF, 1'b0);
    send(9'h100, 1'b0);
    send(9'h1FE, 1'b0);
    chk_out("allneg", 1'b1, 9'h1FF, 5'd4);

    // -0 beats +0, early close
    send(9'h000, 1'b0);
    send(9'h100, 1'b1);
    chk_out("zero_early", 1'b1, 9'h100, 5'd2);

    // Fresh window, in_last on first sample
    send(9'h009, 1'b1);
    chk_out("single", 1'b1, 9'h009, 5'd1);

    // Backpressure: result held, input frozen
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 9'h101;
    in_last   = 1'b1;
    #1;
    chk("bp_in_ready_comb", {8'h0, in_ready}, 9'h000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", {8'h0, in_ready}, 9'h000);
      chk_out("bp_hold", 1'b1, 9'h009, 5'd1);
    end

    // Release: same-cycle consume and completion, no bubble
    out_ready = 1'b1;
    send(9'h021, 1'b1);
    chk_out("stream1_w0", 1'b1, 9'h021, 5'd1);
    send(9'h122, 1'b1);
    chk_out("stream1_w1", 1'b1, 9'h122, 5'd1);
    send(9'h023, 1'b1);
    chk_out("stream1_w2", 1'b1, 9'h023, 5'd1);

    // Three full back-to-back windows
    stream = '{9'h030, 9'h031, 9'h032, 9'h033,
               9'h105, 9'h106, 9'h004, 9'h007,
               9'h100, 9'h000, 9'h0FF, 9'h101};
    smin   = '{9'h030, 9'h106, 9'h101};
    for (int i = 0; i < 12; i++) begin
      chk("stream4_in_ready", {8'h0, in_ready}, 9'h001);
      send(stream[i], 1'b0);
      if (i % 4 == 3)
        chk_out("stream4_res", 1'b1, smin[i / 4], 5'd4);
      else
        chk("stream4_idle", {8'h0, out_valid}, 9'h000);
    end

    // Reset mid-window discards partial state
    send(9'h1FF, 1'b0);
    send(9'h001, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_out("midrst", 1'b0, 9'h000, 5'd0);
    chk("midrst_in_ready", {8'h0, in_ready}, 9'h001);
    rst_n = 1'b1;
    send(9'h005, 1'b0);
    send(9'h006, 1'b0);
    send(9'h007, 1'b0);
    chk("midrst_not_yet", {8'h0, out_valid}, 9'h000);
    send(9'h008, 1'b0);
    chk_out("midrst_win", 1'b1, 9'h005, 5'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/minpool_9bit.md
# minpool_9bit

Streaming min-pooling stage for 9-bit sign-magnitude activations, placed directly downstream of the ALU's 9-bit min datapath in the pooling path. Accepts one sample per cycle over a valid/ready handshake. Reduces each window of WINDOW consecutive samples, or a shorter window closed by `in_last`, to its minimum. Emits one registered result per window with its sample count.

## Interface
- `WINDOW`, 4: samples per window; legal range 2..16.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on rising edge of `clk`.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  block can accept a sample this cycle.
- `in_data`  in  9  sample; bit 8 is sign (1 = negative), bits 7:0 are magnitude.
- `in_last`  in  1  sample closes the current window early; ignored unless a transfer occurs.
- `out_valid`  out  1  result register holds an unconsumed result.
- `out_ready`  in  1  downstream accepts result.
- `out_data`  out  9  window minimum, sign-magnitude.
- `out_count`  out  5  samples in the reported window, 1..WINDOW.

## Operation
- Ordering rule, min(a,b):
  - Signs differ: the operand with sign = 1 wins. This includes 9'h100 (−0) beating 9'h000 (+0).
  - Both positive: the smaller magnitude wins.
  - Both negative: the larger magnitude wins.
  - Equal operands: either, since the bits are identical.
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`, combinational. There is no combinational path from `in_valid` to `in_ready`.
- Two states:
  - IDLE: no samples held for the current window. Reset state.
  - ACCUM: 1..WINDOW−1 samples held in `acc`, with count in `cnt`.
- On an input transfer, let `m` = `in_data` in IDLE, or min(`acc`, `in_data`) in ACCUM. Let `n` = `cnt` + 1 (`cnt` = 0 in IDLE).
  - If `in_last` or `n == WINDOW`:
    - `out_data` ← `m`, `out_count` ← `n`, `out_valid` ← 1.
    - `cnt` ← 0, next state IDLE.
  - Otherwise: `acc` ← `m`, `cnt` ← `n`, next state ACCUM.
- Output transfer with no window completing in the same cycle: `out_valid` ← 0. `out_data` and `out_count` hold their values.
- Output transfer and window completion in the same cycle: the new result overwrites the register and `out_valid` stays 1. There is no bubble.
- While `out_valid && !out_ready`:
  - `out_data` and `out_count` are stable.
  - `in_ready` = 0 and accumulator state is frozen.
- `in_last` on the first sample of a window gives `out_count` = 1 with `out_data` = `in_data`.
- Reset, at any time including mid-window or with a result pending:
  - Partial window and pending result are discarded.
  - `out_valid` = 0, `out_data` = 9'h000, `out_count` = 0, `cnt` = 0, state IDLE.
  - `in_ready` = 1 in the first cycle after reset.

## Timing
- Latency: `out_valid` rises on the clock edge that accepts the window's final sample. The result is visible in the following cycle.
- Throughput: one sample per cycle when `out_ready` = 1. Back-to-back windows run with no idle cycles.
- All outputs except `in_ready` are registered.
- Compare path: one 9-bit sign-magnitude min between `acc` and `in_data` per cycle, with no multicycle paths.

## Test plan
- Reset:
  - Stimulus: hold `rst_n` = 0 for 3 cycles, with `in_valid` = 1 throughout.
  - Response: `out_valid` = 0, `out_data` = 9'h000, `out_count` = 0, `in_ready` = 1. No sample is counted.
- Mixed signs, WINDOW = 4:
  - Stimulus: 9'h003, 9'h105, 9'h007, 9'h102 on consecutive cycles.
  - Response: `out_data` = 9'h105, `out_count` = 4, `out_valid` high the cycle after the 4th accept.
- All positive:
  - Stimulus: 9'h010, 9'h004, 9'h0FF, 9'h004.
  - Response: 9'h004.
- All negative:
  - Stimulus: 9'h181, 9'h1FF, 9'h100, 9'h1FE.
  - Response: 9'h1FF.
- Zero handling and early close:
  - Stimulus: 9'h000, then 9'h100 with `in_last` = 1.
  - Response: `out_data` = 9'h100, `out_count` = 2. The next window starts fresh.
- Backpressure and streaming:
  - Stimulus: hold `out_ready` = 0 after a window completes.
  - Response: `in_ready` = 0 and `out_data` is stable for 5 cycles. After `out_ready` is released, 3 back-to-back windows produce 3 results with `out_valid` continuously high.
- Reset mid-window:
  - Stimulus: accept 9'h1FF and 9'h001, pulse `rst_n` low, then send 9'h005, 9'h006, 9'h007, 9'h008.
  - Response: `out_data` = 9'h005, `out_count` = 4.
